// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache: FSM states,
// line geometry and the bus read tag.
`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'h1
`endif

package icache_pkg;

    localparam int LINE_BYTES  = 64;
    localparam int OFFSET_BITS = 6;
    localparam int LINE_BEATS  = 8;
    localparam int WORD_BITS   = 3;

    localparam logic [12:0] READ_TAG = {1'b1, `SYSBUS_MEMORY, 8'b0};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        MISS_REQ  = 3'd2,
        MISS_FILL = 3'd3,
        RESPOND   = 3'd4,
        FLUSH     = 3'd5
    } state_t;

endpackage

// File: rtl/icache_data_array.sv
// One way of cache data storage: N_SETS lines of LINE_BEATS words,
// synchronous write, combinational read, addressed by {set, word}.
module icache_data_array
    import icache_pkg::*;
#(
    parameter int N_SETS = 64,
    parameter int WIDTH  = 64,
    localparam int AW    = $clog2(N_SETS) + WORD_BITS
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [N_SETS*LINE_BEATS];

    // NOTE: storage is deliberately not reset; the top-level valid bits decide what is usable.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/icache_sa.sv
// Read-only set-associative instruction cache (1 or 2 ways, LRU, whole-cache
// flush) that fills 64-byte lines from the system bus in 8-beat bursts.
module icache_sa
    import icache_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int N_SETS         = 64,
    parameter int N_WAYS         = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      p_req_valid,
    input  logic [63:0]               p_req_addr,
    output logic                      p_req_ready,
    output logic                      p_resp_valid,
    output logic [63:0]               p_resp_data,
    input  logic                      p_resp_ready,
    input  logic                      p_flush,
    output logic                      m_bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
    input  logic                      m_bus_reqack,
    input  logic                      m_bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag,
    output logic                      m_bus_respack
);

    localparam int IDX   = $clog2(N_SETS);
    localparam int TAG_W = 64 - OFFSET_BITS - IDX;

    state_t                  state;
    logic [63:WORD_BITS]     addr_q;
    logic [2:0]              beat_cnt;
    logic [IDX-1:0]          flush_cnt;
    logic                    flush_pending;
    logic                    fill_way;
    logic [63:0]             resp_q;

    logic                    valid [N_WAYS][N_SETS];
    logic [TAG_W-1:0]        tags  [N_WAYS][N_SETS];
    logic                    lru   [N_SETS];

    logic [IDX-1:0]          set_q;
    logic [2:0]              word_q;
    logic [TAG_W-1:0]        tag_q;
    logic                    hit;
    logic                    hit_way;
    logic                    victim_sel;
    logic [BUS_DATA_WIDTH-1:0] way_rdata [N_WAYS];
    logic                    unused;

    assign set_q  = addr_q[OFFSET_BITS+IDX-1:OFFSET_BITS];
    assign word_q = addr_q[OFFSET_BITS-1:WORD_BITS];
    assign tag_q  = addr_q[63:OFFSET_BITS+IDX];
    assign unused = ^{m_bus_resptag, p_req_addr[WORD_BITS-1:0]};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit     = 1'b0;
        hit_way = 1'b0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (valid[w][set_q] && tags[w][set_q] == tag_q) begin
                hit     = 1'b1;
                hit_way = 1'(w);
            end
        end
    end

    // Descending scan so the lowest-numbered invalid way wins over LRU.
    always_comb begin
        victim_sel = (N_WAYS > 1) ? lru[set_q] : 1'b0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (!valid[w][set_q]) victim_sel = 1'(w);
        end
    end

    for (genvar w = 0; w < N_WAYS; w++) begin : g_way
        icache_data_array #(
            .N_SETS (N_SETS),
            .WIDTH  (BUS_DATA_WIDTH)
        ) u_data (
            .clk   (clk),
            .we    (state == MISS_FILL && m_bus_respcyc && fill_way == 1'(w)),
            .waddr ({set_q, beat_cnt}),
            .wdata (m_bus_resp),
            .raddr ({set_q, word_q}),
            .rdata (way_rdata[w])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            addr_q        <= '0;
            beat_cnt      <= '0;
            flush_cnt     <= '0;
            flush_pending <= 1'b0;
            fill_way      <= 1'b0;
            resp_q        <= '0;
            for (int s = 0; s < N_SETS; s++) begin
                lru[s] <= 1'b0;
                for (int w = 0; w < N_WAYS; w++) begin
                    valid[w][s] <= 1'b0;
                    tags[w][s]  <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (p_flush || flush_pending) begin
                        state         <= FLUSH;
                        flush_pending <= 1'b0;
                        flush_cnt     <= '0;
                    end else if (p_req_valid) begin
                        addr_q <= p_req_addr[63:WORD_BITS];
                        state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        resp_q <= way_rdata[hit_way];
                        if (N_WAYS > 1) lru[set_q] <= ~hit_way;
                        state  <= RESPOND;
                    end else begin
                        fill_way <= victim_sel;
                        state    <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (m_bus_reqack) begin
                        beat_cnt <= '0;
                        state    <= MISS_FILL;
                    end
                end
                MISS_FILL: begin
                    if (m_bus_respcyc) begin
                        beat_cnt <= beat_cnt + 3'd1;
                        if (beat_cnt == 3'd0) valid[fill_way][set_q] <= 1'b0;
                        if (beat_cnt == word_q) resp_q <= m_bus_resp;
                        if (beat_cnt == 3'(LINE_BEATS - 1)) begin
                            tags[fill_way][set_q]  <= tag_q;
                            valid[fill_way][set_q] <= 1'b1;
                            if (N_WAYS > 1) lru[set_q] <= ~fill_way;
                            state <= RESPOND;
                        end
                    end
                end
                RESPOND: begin
                    if (p_resp_ready) state <= IDLE;
                end
                FLUSH: begin
                    for (int w = 0; w < N_WAYS; w++) valid[w][flush_cnt] <= 1'b0;
                    lru[flush_cnt] <= 1'b0;
                    flush_cnt      <= flush_cnt + 1'b1;
                    if (flush_cnt == IDX'(N_SETS - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A pulse seen mid-transaction is remembered and serviced from IDLE.
            if (p_flush && state != IDLE) flush_pending <= 1'b1;
        end
    end

    assign p_req_ready   = reset && state == IDLE && !p_flush && !flush_pending;
    assign p_resp_valid  = state == RESPOND;
    assign p_resp_data   = resp_q;
    assign m_bus_reqcyc  = state == MISS_REQ;
    assign m_bus_req     = m_bus_reqcyc ? BUS_DATA_WIDTH'({addr_q[63:OFFSET_BITS], 6'b0}) : '0;
    assign m_bus_reqtag  = m_bus_reqcyc ? BUS_TAG_WIDTH'(READ_TAG) : '0;
    assign m_bus_respack = state == MISS_FILL && m_bus_respcyc;

endmodule

// File: tb/tb_icache_sa.sv
// Bench for icache_sa: a 2-way and a direct-mapped instance, a tag-order
// cache model, a per-cycle output monitor and directed access sequences.
module tb_icache_sa;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid [2];
    logic [63:0] req_addr  [2];
    logic        req_ready [2];
    logic        resp_valid[2];
    logic [63:0] resp_data [2];
    logic        resp_ready[2];
    logic        flush     [2];
    logic        reqcyc    [2];
    logic [63:0] breq      [2];
    logic [12:0] reqtag    [2];
    logic        reqack    [2];
    logic        respcyc   [2];
    logic [63:0] bresp     [2];
    logic [12:0] resptag   [2];
    logic        respack   [2];

    icache_sa #(.N_SETS(64), .N_WAYS(2)) dut_2way (
        .clk(clk), .reset(reset),
        .p_req_valid(req_valid[0]), .p_req_addr(req_addr[0]), .p_req_ready(req_ready[0]),
        .p_resp_valid(resp_valid[0]), .p_resp_data(resp_data[0]), .p_resp_ready(resp_ready[0]),
        .p_flush(flush[0]),
        .m_bus_reqcyc(reqcyc[0]), .m_bus_req(breq[0]), .m_bus_reqtag(reqtag[0]),
        .m_bus_reqack(reqack[0]), .m_bus_respcyc(respcyc[0]), .m_bus_resp(bresp[0]),
        .m_bus_resptag(resptag[0]), .m_bus_respack(respack[0])
    );

    icache_sa #(.N_SETS(64), .N_WAYS(1)) dut_1way (
        .clk(clk), .reset(reset),
        .p_req_valid(req_valid[1]), .p_req_addr(req_addr[1]), .p_req_ready(req_ready[1]),
        .p_resp_valid(resp_valid[1]), .p_resp_data(resp_data[1]), .p_resp_ready(resp_ready[1]),
        .p_flush(flush[1]),
        .m_bus_reqcyc(reqcyc[1]), .m_bus_req(breq[1]), .m_bus_reqtag(reqtag[1]),
        .m_bus_reqack(reqack[1]), .m_bus_respcyc(respcyc[1]), .m_bus_resp(bresp[1]),
        .m_bus_resptag(resptag[1]), .m_bus_respack(respack[1])
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Backing memory: every aligned word is a fixed function of its address.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A5A5A, ~a[31:0]};
    endfunction

    // Cache model: per set, resident tags in most-recent-first order.
    logic [63:0] m_tag [2][64][2];
    int          m_cnt [2][64];

    function automatic void model_flush(input int k);
        for (int s = 0; s < 64; s++) m_cnt[k][s] = 0;
    endfunction

    function automatic bit model_access(input int k, input logic [63:0] a);
        int          s    = int'(a[11:6]);
        logic [63:0] t    = a >> 12;
        int          ways = (k == 0) ? 2 : 1;
        for (int i = 0; i < m_cnt[k][s]; i++) begin
            if (m_tag[k][s][i] == t) begin
                if (i == 1) begin
                    m_tag[k][s][1] = m_tag[k][s][0];
                    m_tag[k][s][0] = t;
                end
                return 1'b0;
            end
        end
        if (ways == 2) m_tag[k][s][1] = m_tag[k][s][0];
        m_tag[k][s][0] = t;
        if (m_cnt[k][s] < ways) m_cnt[k][s]++;
        return 1'b1;
    endfunction

    // Per-cycle monitor, sampled mid-low-phase after the driver has settled.
    logic [63:0] exp_line [2];
    logic [63:0] exp_data [2];
    int          bus_reqs [2];
    logic        prev_reqcyc [2];

    always @(negedge clk) begin
        #2;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("respack_follows_respcyc[%0d]", k), 64'(respack[k]), 64'(respcyc[k]));
            if (reqcyc[k]) begin
                check($sformatf("bus_req_addr[%0d]", k), breq[k], exp_line[k]);
                check($sformatf("bus_req_tag[%0d]", k), 64'(reqtag[k]), 64'h1100);
                if (!prev_reqcyc[k]) bus_reqs[k]++;
            end
            prev_reqcyc[k] = reqcyc[k];
            if (resp_valid[k]) check($sformatf("resp_data[%0d]", k), resp_data[k], exp_data[k]);
        end
    end

    // One processor transaction, also acting as the bus slave on a miss.
    task automatic access(input int k, input logic [63:0] a, input int ack_delay, input int gap,
                          input int hold, input int flush_beat, input int abort_beat,
                          output bit miss, output logic [63:0] data);
        bit exp_miss;
        bit acc;
        int t;
        exp_miss    = model_access(k, a);
        exp_line[k] = {a[63:6], 6'b0};
        exp_data[k] = mem_word({a[63:3], 3'b0});
        miss = 1'b0;
        data = '0;

        @(negedge clk);
        req_valid[k] = 1'b1;
        req_addr[k]  = a;
        t = 0;
        #1 acc = req_ready[k];
        while (!acc && t < 200) begin
            @(negedge clk);
            #1 acc = req_ready[k];
            t++;
        end
        check("request_accepted", 64'(acc), 64'd1);
        if (!acc) begin
            req_valid[k] = 1'b0;
            return;
        end

        @(negedge clk);
        req_valid[k] = 1'b0;
        check("lookup_cycle_quiet", {62'd0, resp_valid[k], reqcyc[k]}, 64'd0);
        @(negedge clk);
        miss = reqcyc[k];
        check("hit_or_miss", 64'(miss), 64'(exp_miss));

        if (!miss) begin
            check("hit_latency", 64'(resp_valid[k]), 64'd1);
        end else begin
            repeat (ack_delay) begin
                @(negedge clk);
                check("reqcyc_held", 64'(reqcyc[k]), 64'd1);
            end
            reqack[k] = 1'b1;
            @(negedge clk);
            reqack[k] = 1'b0;
            for (int b = 0; b < 8; b++) begin
                if (gap != 0 && (b % 3) == 1) begin
                    respcyc[k] = 1'b0;
                    repeat (2) @(negedge clk);
                end
                respcyc[k] = 1'b1;
                bresp[k]   = mem_word(exp_line[k] + 64'(8 * b));
                if (b == flush_beat) flush[k] = 1'b1;
                @(negedge clk);
                flush[k] = 1'b0;
                if (b == abort_beat) begin
                    respcyc[k] = 1'b0;
                    reset      = 1'b0;
                    #1;
                    check("reset_outputs_zero",
                          {57'd0, req_ready[k], resp_valid[k], reqcyc[k], respack[k],
                           |breq[k], |reqtag[k], |resp_data[k]}, 64'd0);
                    model_flush(0);
                    model_flush(1);
                    @(negedge clk);
                    reset = 1'b1;
                    return;
                end
            end
            respcyc[k] = 1'b0;
            check("fill_resp_latency", 64'(resp_valid[k]), 64'd1);
        end

        repeat (hold) begin
            check("hold_req_ready_low", 64'(req_ready[k]), 64'd0);
            check("hold_resp_valid", 64'(resp_valid[k]), 64'd1);
            @(negedge clk);
        end
        data = resp_data[k];
        resp_ready[k] = 1'b1;
        @(negedge clk);
        resp_ready[k] = 1'b0;
        check("resp_retired", 64'(resp_valid[k]), 64'd0);
    endtask

    // Counts cycles with p_req_ready low, starting at the current negedge.
    task automatic count_not_ready(input int k, output int n);
        logic r;
        n = 0;
        #1 r = req_ready[k];
        while (!r && n < 500) begin
            @(negedge clk);
            #1 r = req_ready[k];
            n++;
        end
    endtask

    bit          miss;
    logic [63:0] data;
    int          n;
    int          base;

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0; req_addr[k] = '0; resp_ready[k] = 1'b0; flush[k] = 1'b0;
            reqack[k] = 1'b0; respcyc[k] = 1'b0; bresp[k] = '0; resptag[k] = '0;
            exp_line[k] = '0; exp_data[k] = '0; bus_reqs[k] = 0; prev_reqcyc[k] = 1'b0;
        end
        model_flush(0);
        model_flush(1);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++)
            check("reset_state_outputs",
                  {57'd0, req_ready[k], resp_valid[k], reqcyc[k], respack[k],
                   |breq[k], |reqtag[k], |resp_data[k]}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ready_after_reset_2way", 64'(req_ready[0]), 64'd1);
        check("ready_after_reset_1way", 64'(req_ready[1]), 64'd1);

        // Cold miss then a hit on the last word of the same line.
        access(0, 64'h1000, 0, 0, 0, -1, -1, miss, data);
        check("cold_miss", 64'(miss), 64'd1);
        check("cold_miss_word0", data, 64'h5A5A4A5A_FFFFEFFF);
        access(0, 64'h1038, 0, 0, 0, -1, -1, miss, data);
        check("line_hit", 64'(miss), 64'd0);
        check("line_hit_word7", data, 64'h5A5A4A62_FFFFEFC7);

        // Two-way LRU in set 0.
        access(0, 64'h0000, 0, 0, 0, -1, -1, miss, data);
        check("lru_fill_0", 64'(miss), 64'd1);
        access(0, 64'h0000, 0, 0, 0, -1, -1, miss, data);
        check("lru_hit_0", 64'(miss), 64'd0);
        access(0, 64'h2000, 0, 0, 0, -1, -1, miss, data);
        check("lru_miss_2000", 64'(miss), 64'd1);
        access(0, 64'h0000, 0, 0, 0, -1, -1, miss, data);
        check("lru_0_kept", 64'(miss), 64'd0);
        access(0, 64'h1000, 0, 0, 0, -1, -1, miss, data);
        check("lru_1000_evicted", 64'(miss), 64'd1);

        // Direct-mapped conflict: every access misses.
        base = bus_reqs[1];
        access(1, 64'h0000, 0, 0, 0, -1, -1, miss, data);
        check("dm_miss_a", 64'(miss), 64'd1);
        access(1, 64'h1000, 0, 0, 0, -1, -1, miss, data);
        check("dm_miss_b", 64'(miss), 64'd1);
        access(1, 64'h0000, 0, 0, 0, -1, -1, miss, data);
        check("dm_miss_c", 64'(miss), 64'd1);
        check("dm_bus_requests", 64'(bus_reqs[1] - base), 64'd3);

        // Flush from IDLE.
        access(0, 64'h0040, 0, 0, 0, -1, -1, miss, data);
        @(negedge clk);
        flush[0] = 1'b1;
        #1 check("flush_blocks_ready", 64'(req_ready[0]), 64'd0);
        @(negedge clk);
        flush[0] = 1'b0;
        count_not_ready(0, n);
        check("flush_duration", 64'(n), 64'd64);
        model_flush(0);
        access(0, 64'h0040, 0, 0, 0, -1, -1, miss, data);
        check("miss_after_flush", 64'(miss), 64'd1);

        // Flush pulse during a fill: response first, then the flush.
        access(0, 64'h0080, 0, 0, 0, 3, -1, miss, data);
        check("fill_before_flush", 64'(miss), 64'd1);
        check("fill_before_flush_data", data, mem_word(64'h0080));
        count_not_ready(0, n);
        check("pending_flush_duration", 64'(n), 64'd65);
        model_flush(0);
        access(0, 64'h0040, 0, 0, 0, -1, -1, miss, data);
        check("miss_after_pending_flush", 64'(miss), 64'd1);

        // Backpressure on every handshake.
        access(0, 64'h3018, 5, 1, 3, -1, -1, miss, data);
        check("backpressure_miss", 64'(miss), 64'd1);
        check("backpressure_data", data, mem_word(64'h3018));

        // Reset in the middle of a fill, then the line must refetch in full.
        access(0, 64'h5000, 0, 0, 0, -1, 3, miss, data);
        access(0, 64'h5000, 0, 0, 0, -1, -1, miss, data);
        check("partial_line_invalid", 64'(miss), 64'd1);
        access(0, 64'h1000, 0, 0, 0, -1, -1, miss, data);
        check("miss_after_reset", 64'(miss), 64'd1);
        check("miss_after_reset_data", data, 64'h5A5A4A5A_FFFFEFFF);
        access(0, 64'h1000, 0, 0, 0, -1, -1, miss, data);
        check("hit_after_refill", 64'(miss), 64'd0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
